// File: rtl/demux_1_to_2_sched.sv
// demux_1_to_2_sched: packet-level 1-to-2 steering with one small FIFO per sink.
// The destination is latched on the first beat of a packet and held until its
// last beat. Each sink has its own FIFO, so a stalled sink only blocks packets
// that are headed to it.
// Optional feature macro: DEMUX_1_TO_2_SCHED_STATS_EN adds per-sink packet
// counters (pkt_count_x, pkt_count_y).
module demux_1_to_2_sched #(
    parameter int bits  = 16,
    parameter int depth = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [bits-1:0] in_data,
    input  logic            in_select,
    input  logic            in_last,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [bits-1:0] out_x_data,
    output logic            out_x_last,
    output logic            out_x_valid,
    input  logic            out_x_ready,
    output logic [bits-1:0] out_y_data,
    output logic            out_y_last,
    output logic            out_y_valid,
    input  logic            out_y_ready,
    output logic            busy,
    output logic            route
`ifdef DEMUX_1_TO_2_SCHED_STATS_EN
    ,
    output logic [15:0]     pkt_count_x,
    output logic [15:0]     pkt_count_y
`endif
);

    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int cw = $clog2(depth + 1);
    localparam logic [cw-1:0] full_count = cw'(depth);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_X = 2'd1,
        ROUTE_Y = 2'd2
    } state_t;

    state_t          state_reg;
    logic            busy_reg;
    logic            route_reg;
    logic            dest;
    logic            accept;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      sink_ready;
    logic [1:0]      sink_valid;
    logic [1:0]      head_last;
    logic [bits-1:0] head_data [2];
    logic [cw-1:0]   fill [2];
`ifdef DEMUX_1_TO_2_SCHED_STATS_EN
    logic [15:0]     pkt_cnt [2];
`endif

    assign sink_ready = {out_y_ready, out_x_ready};

    // Destination: follows in_select between packets, frozen while a packet is open.
    always_comb begin
        dest = 1'b0;
        case (state_reg)
            IDLE:    dest = in_select;
            ROUTE_Y: dest = 1'b1;
            default: dest = 1'b0;
        endcase
    end

    // Ready only looks at the fill level before this cycle's pop (no push-through).
    assign in_ready = (fill[dest] < full_count);
    assign accept   = in_valid && in_ready;

    // Packet FSM with registered busy/route flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            route_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && !in_last) begin
                        state_reg <= in_select ? ROUTE_Y : ROUTE_X;
                        busy_reg  <= 1'b1;
                        route_reg <= in_select;
                    end
                end
                ROUTE_X, ROUTE_Y: begin
                    if (accept && in_last) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        route_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    route_reg <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [bits-1:0]  mem_data_reg [depth];
            logic [depth-1:0] mem_last_reg;
            logic [aw-1:0]    wr_ptr_reg;
            logic [aw-1:0]    rd_ptr_reg;
            logic [cw-1:0]    count_reg;
            logic [cw-1:0]    count_next;
            logic             valid_reg;

            assign push[gi]       = accept && (dest == 1'(gi));
            assign pop[gi]        = valid_reg && sink_ready[gi];
            assign fill[gi]       = count_reg;
            assign sink_valid[gi] = valid_reg;
            assign head_data[gi]  = mem_data_reg[rd_ptr_reg];
            assign head_last[gi]  = mem_last_reg[rd_ptr_reg];

            // Occupancy update; simultaneous push and pop leave it unchanged.
            always_comb begin
                count_next = count_reg;
                if (push[gi] && !pop[gi]) begin
                    count_next = count_reg + 1'b1;
                end else if (!push[gi] && pop[gi]) begin
                    count_next = count_reg - 1'b1;
                end
            end

            // Storage, wrapping pointers and a registered non-empty flag.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < depth; i++) begin
                        mem_data_reg[i] <= '0;
                    end
                    mem_last_reg <= '0;
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    valid_reg    <= 1'b0;
                end else begin
                    if (push[gi]) begin
                        mem_data_reg[wr_ptr_reg] <= in_data;
                        mem_last_reg[wr_ptr_reg] <= in_last;
                        wr_ptr_reg               <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    count_reg <= count_next;
                    valid_reg <= (count_next != '0);
                end
            end

`ifdef DEMUX_1_TO_2_SCHED_STATS_EN
            logic [15:0] pkt_cnt_reg;
            assign pkt_cnt[gi] = pkt_cnt_reg;

            // Counts packets (last beats) accepted into this sink's FIFO; wraps naturally.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    pkt_cnt_reg <= '0;
                end else if (push[gi] && in_last) begin
                    pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
                end
            end
`endif
        end
    endgenerate

    assign out_x_data  = head_data[0];
    assign out_x_last  = head_last[0];
    assign out_x_valid = sink_valid[0];
    assign out_y_data  = head_data[1];
    assign out_y_last  = head_last[1];
    assign out_y_valid = sink_valid[1];
    assign busy        = busy_reg;
    assign route       = route_reg;
`ifdef DEMUX_1_TO_2_SCHED_STATS_EN
    assign pkt_count_x = pkt_cnt[0];
    assign pkt_count_y = pkt_cnt[1];
`endif

endmodule

// File: doc/demux_1_to_2_sched.md
# demux_1_to_2_sched

Packet-level scheduler for the 1-to-2 data steering path. Takes one valid/ready input stream, latches a destination (x or y) on the first beat of each packet, holds that routing until the packet's last beat, and buffers each destination in its own small FIFO so one stalled sink does not block the other between packets. Sits between a single producer (e.g. a CRP16 bus master) and two consumers that would otherwise share a plain 1-to-2 demux.

## Interface
- bits, 16, data width of every data port
- depth, 2, entries per output FIFO; power of two, ≥2
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  bits  input beat data
- in_select  in  1  destination of the packet: 0 = x, 1 = y; sampled on the first beat only
- in_last  in  1  marks the final beat of a packet
- in_valid  in  1  input beat present
- in_ready  out  1  scheduler accepts the beat this cycle
- out_x_data / out_y_data  out  bits  head-of-FIFO data for each sink
- out_x_last / out_y_last  out  1  last flag travelling with the beat
- out_x_valid / out_y_valid  out  1  sink FIFO non-empty
- out_x_ready / out_y_ready  in  1  sink takes the head beat
- busy  out  1  packet in progress (state not IDLE)
- route  out  1  latched destination; meaningful only while busy

## Operation
- Beat accepted when in_valid && in_ready; popped from a sink when out_*_valid && out_*_ready.
- FSM states: IDLE, ROUTE_X, ROUTE_Y.
  - IDLE: destination = in_select. On accept: push to that FIFO; if in_last, stay IDLE; else go to ROUTE_X (select 0) or ROUTE_Y (select 1).
  - ROUTE_X/ROUTE_Y: destination fixed; in_select ignored. On accept with in_last → IDLE; otherwise stay.
- in_ready = destination FIFO count < depth. Purely combinational from state, in_select (IDLE only) and count; never depends on in_valid.
- Full FIFO: no push-through. A simultaneous pop on a full FIFO does not raise in_ready in that cycle.
- Each FIFO is independent: it pushes on accept, pops on sink handshake, and push and pop in the same cycle leave the count unchanged. Pointers wrap modulo depth.
- The non-selected FIFO keeps draining while the other is filling.
- route = 0 in ROUTE_X, 1 in ROUTE_Y, 0 in IDLE. busy = (state != IDLE).
- Beats within a packet reach their sink in order. Packets to different sinks have no ordering relation.
- Reset (any time, including mid-packet): state → IDLE, both FIFOs emptied, buffered beats discarded.

## Timing
- Reset values: out_*_valid = 0, out_*_data = 0, out_*_last = 0, busy = 0, route = 0. in_ready = 1 once reset_n deasserts, because both FIFOs are empty.
- Latency: a beat accepted at edge N shows out_*_valid = 1 after edge N. The sink sees it in cycle N+1.
- Throughput: one beat per cycle per packet while the sink takes one beat per cycle. depth = 2 sustains full rate.
- All outputs except in_ready are registered. in_ready is the only combinational output.

## Configuration
- DEMUX_1_TO_2_SCHED_STATS_EN defined:
  - Adds outputs pkt_count_x and pkt_count_y (16 bits each).
  - Each counter increments when a beat with last = 1 is accepted into that FIFO. Counters wrap 0xFFFF→0x0000 and reset to 0.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Single-beat packets: in_data 0x1234 (select 0, last 1), then 0xABCD (select 1, last 1), with both sinks ready → 0x1234 on x in cycle N+1, 0xABCD on y in cycle N+2; busy stays 0.
- 4-beat packet to y with in_select toggling every beat after the first → all 4 beats on y, none on x; route = 1 while busy; busy falls after the last beat.
- out_x_ready = 0 during a 5-beat x packet, depth 2 → in_ready drops after 2 beats. Releasing out_x_ready delivers 5 beats in order; in_ready does not rise in the cycle of the first pop on a full FIFO.
- x sink stalled holding 2 beats, then a y packet of 3 beats → y packet flows at full rate; x contents untouched.
- Assert reset_n mid-packet with both FIFOs non-empty → all valid = 0 and busy = 0 immediately. After release, the next beat's in_select is honoured.
- With DEMUX_1_TO_2_SCHED_STATS_EN: preload pkt_count_x near 0xFFFF via 65535 single-beat packets (or force), send 2 more → count reads 0x0001; pkt_count_y unchanged.
